// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter feeding the sin_r/sin_l input of shift_reg.
// Optional macro PISO_PARITY_EN appends one even-parity bit (state PAR) to every frame.
module piso_shift_tx #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    // state | meaning
    // IDLE  | no frame; load_ready=1, outputs quiet
    // SHIFT | data bit cnt_q is on sout (WIDTH cycles)
    // PAR   | parity bit on sout (PISO_PARITY_EN only)
`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               sout_q, sout_d;
    logic               sout_valid_q, sout_valid_d;
    logic               last_q, last_d;
    logic               data_done;
    logic               frame_end;
    logic               accept;
`ifdef PISO_PARITY_EN
    logic               par_q, par_d;
`endif

    assign data_done = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
`ifdef PISO_PARITY_EN
    assign frame_end = (state_q == PAR);
`else
    assign frame_end = data_done;
`endif

    assign load_ready = (state_q == IDLE) || frame_end;
    assign accept     = load_valid && load_ready;
    assign busy       = (state_q != IDLE);
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign last       = last_q;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        last_d       = 1'b0;
`ifdef PISO_PARITY_EN
        par_d        = par_q;
`endif
        if (state_q == SHIFT && !data_done) begin
            cnt_d        = cnt_q + CNT_W'(1);
            sout_d       = mode_q ? sr_q[0] : sr_q[WIDTH-1];
            sr_d         = mode_q ? {1'b0, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], 1'b0};
            sout_valid_d = 1'b1;
`ifndef PISO_PARITY_EN
            last_d       = (cnt_q == CNT_W'(WIDTH - 2));
`endif
`ifdef PISO_PARITY_EN
        end else if (data_done) begin
            state_d      = PAR;
            sout_d       = par_q;
            sout_valid_d = 1'b1;
            last_d       = 1'b1;
`endif
        end else if (accept) begin
            // First bit is registered at the accept edge; sr keeps the remainder.
            state_d      = SHIFT;
            cnt_d        = '0;
            mode_d       = mode;
            sout_d       = mode ? din[0] : din[WIDTH-1];
            sr_d         = mode ? {1'b0, din[WIDTH-1:1]} : {din[WIDTH-2:0], 1'b0};
            sout_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
            par_d        = ^din;
`endif
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            last_q       <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            last_q       <= last_d;
`ifdef PISO_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in serial-out transmitter. It is the sending end for the team's bidirectional serial-in shift register `shift_reg`.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock.
- Bit order is chosen by `mode`, so that a `shift_reg` set to the same mode and clocked on the same edges ends with Q equal to the transmitted word.
- Sits between a parallel data source and the `sin_r`/`sin_l` serial input of the receiver.

Parameters:
- WIDTH, 4: data word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1): bit counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset; one clock, asynchronous active-low reset.
- din  input  WIDTH  parallel word to send; sampled only on an accepted load.
- mode  input  1  sampled on an accepted load. 1 = right-shift order (LSB first, drives the receiver's sin_r). 0 = left-shift order (MSB first, drives the receiver's sin_l).
- load_valid  input  1  source has a word on din.
- load_ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- last  output  1  high during the final bit cycle of a frame.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, last=0, busy=0. load_ready is a decode of state, so it reads 1 once in IDLE.
- Reset asserted mid-frame aborts the frame immediately. No partial bits are emitted after release.
- States:
  - IDLE: load_ready=1, sout_valid=0, sout=0.
  - SHIFT: WIDTH cycles, one bit per cycle.
  - PAR: only with the optional feature enabled.
- Transitions:
  - IDLE→SHIFT on edge with load_valid&&load_ready.
  - SHIFT→SHIFT while cnt<WIDTH-1.
  - At the final bit: next frame (SHIFT, cnt=0) if a new load is accepted that edge, otherwise IDLE.
- Accept: at the accept edge, latch din into the shift register and mode into mode_q; cnt=0.
- Latency: the first bit appears on sout in the cycle immediately after the accept edge.
- Output register: sout, sout_valid and last are registered, with no combinational path from inputs.
- Bit order:
  - mode_q=1: sout = sr[0] first; shift right each edge (sr <= {1'b0, sr[WIDTH-1:1]}).
  - mode_q=0: sout = sr[WIDTH-1] first; shift left (sr <= {sr[WIDTH-2:0], 1'b0}).
- Frame length: exactly WIDTH sout_valid cycles. last=1 only when cnt==WIDTH-1.
- Back-to-back:
  - load_ready is also 1 during the last-bit cycle.
  - A load accepted then starts the next frame with no gap; sout_valid stays high continuously.
- Busy rules:
  - load_ready=0 in all other SHIFT cycles.
  - load_valid and din are ignored there; no queuing.
  - din/mode changes mid-frame have no effect.
- No X on outputs at any time after reset.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, state PAR emits one even-parity bit (XOR of the latched word) with sout_valid=1.
  - last moves to the PAR cycle and load_ready is high in PAR instead of the final data cycle.
  - Frame = WIDTH+1 cycles.
- Undefined:
  - PAR state and parity logic are absent; frame = WIDTH cycles as above.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, release → sout=0, sout_valid=0, busy=0, load_ready=1. Assert reset_n=0 mid-frame (after 2 bits) → outputs clear asynchronously, next frame starts clean.
- Right shift: mode=1, din=4'b1010, one-cycle load_valid → sout sequence 0,1,0,1 over 4 cycles; last on 4th; then IDLE.
- Left shift: mode=0, din=4'b1010 → sout 1,0,1,0; busy high for exactly 4 cycles.
- Back-to-back: hold load_valid=1 with din=4'b1100 (mode=1) then 4'b0011 → 8 contiguous sout_valid cycles 0,0,1,1,1,1,0,0; load_ready high only in cycles 4 and 8.
- Busy ignore: during a frame of 4'b1010 (mode=0), drive load_valid=1, din=4'b1111 in bit cycle 2 → sequence unchanged 1,0,1,0; no new frame.
- Loopback: drive sout into `shift_reg` (sin_r when mode=1, sin_l when mode=0, same clk) for din=4'b1010 → receiver Q=4'b1010 after 4 bits in both modes. With PISO_PARITY_EN: din=4'b1011 → 5th bit=1, last on 5th.
